// File: rtl/pf_lanectrl_pause_seq.sv
// Lane-delay update sequencer: holds HS_IO_CLK_PAUSE around a DLY_LOAD strobe and
// acknowledges a four-phase request. Optional post-pause holdoff: PAUSE_SEQ_HOLDOFF_EN.
module pf_lanectrl_pause_seq #(
  parameter int PRE_CYCLES     = 4,
  parameter int LOAD_CYCLES    = 2,
  parameter int POST_CYCLES    = 4,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  // Four-phase handshake: UPD_REQ rises and stays high until UPD_ACK is seen;
  // UPD_ACK stays high until UPD_REQ is low; an accepted pause always runs to completion.
  input  logic       UPD_REQ,
  input  logic [7:0] UPD_CODE,
  output logic       UPD_ACK,
  output logic       HS_IO_CLK_PAUSE,
  output logic       DLY_LOAD,
  output logic [7:0] DLY_CODE,
  output logic       BUSY
);

  if (PRE_CYCLES < 1 || PRE_CYCLES > 15 || LOAD_CYCLES < 1 || LOAD_CYCLES > 15 ||
      POST_CYCLES < 1 || POST_CYCLES > 15 || HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 15)
  begin : g_bad_param
    $error("pf_lanectrl_pause_seq: cycle parameters must be in 1..15");
  end

  localparam logic [3:0] PRE_LD  = 4'(PRE_CYCLES - 1);
  localparam logic [3:0] LOAD_LD = 4'(LOAD_CYCLES - 1);
  localparam logic [3:0] POST_LD = 4'(POST_CYCLES - 1);
`ifdef PAUSE_SEQ_HOLDOFF_EN
  localparam logic [3:0] HOLD_LD = 4'(HOLDOFF_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_LOAD = 3'd2,
    S_POST = 3'd3,
    S_ACK  = 3'd4
`ifdef PAUSE_SEQ_HOLDOFF_EN
    , S_HOLD = 3'd5
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] code_q, code_d;
  logic       ack_q, ack_d;
  logic       pause_q, pause_d;
  logic       load_q, load_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    case (state_q)
      S_IDLE: begin
        if (UPD_REQ) begin
          state_d = S_PRE;
          cnt_d   = PRE_LD;
          code_d  = UPD_CODE;
        end
      end
      S_PRE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_LOAD;
          cnt_d   = LOAD_LD;
        end
      end
      S_LOAD: begin
        if (cnt_q == 4'd0) begin
          state_d = S_POST;
          cnt_d   = POST_LD;
        end
      end
      S_POST: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          cnt_d   = 4'd0;
        end
      end
      S_ACK: begin
        if (!UPD_REQ) begin
`ifdef PAUSE_SEQ_HOLDOFF_EN
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef PAUSE_SEQ_HOLDOFF_EN
      // Requests are deliberately not looked at until the gap has elapsed.
      S_HOLD: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies decoded from the next state, so they switch
    // on the same edge as the state itself.
    pause_d = (state_d == S_PRE) || (state_d == S_LOAD) || (state_d == S_POST);
    load_d  = (state_d == S_LOAD);
    ack_d   = (state_d == S_ACK);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      code_q  <= 8'h00;
      ack_q   <= 1'b0;
      pause_q <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      ack_q   <= ack_d;
      pause_q <= pause_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
    end
  end

  assign UPD_ACK         = ack_q;
  assign HS_IO_CLK_PAUSE = pause_q;
  assign DLY_LOAD        = load_q;
  assign DLY_CODE        = code_q;
  assign BUSY            = busy_q;

endmodule

// File: tb/tb_pf_lanectrl_pause_seq.sv
// Directed bench for pf_lanectrl_pause_seq: default-parameter instance plus a
// PRE=LOAD=POST=1 instance; expectations follow PAUSE_SEQ_HOLDOFF_EN when defined.
module tb_pf_lanectrl_pause_seq;

`ifdef PAUSE_SEQ_HOLDOFF_EN
  localparam bit HOLD_EN = 1'b1;
  localparam int B2B_GAP = 10;
`else
  localparam bit HOLD_EN = 1'b0;
  localparam int B2B_GAP = 2;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       upd_req = 1'b0;
  logic [7:0] upd_code = 8'h00;
  logic       upd_ack, pause, dly_load, busy;
  logic [7:0] dly_code;
  logic       m_upd_req = 1'b0;
  logic [7:0] m_upd_code = 8'h00;
  logic       m_upd_ack, m_pause, m_dly_load, m_busy;
  logic [7:0] m_dly_code;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pf_lanectrl_pause_seq dut (
    .CLK(CLK), .RESET(RESET), .UPD_REQ(upd_req), .UPD_CODE(upd_code),
    .UPD_ACK(upd_ack), .HS_IO_CLK_PAUSE(pause), .DLY_LOAD(dly_load),
    .DLY_CODE(dly_code), .BUSY(busy)
  );

  pf_lanectrl_pause_seq #(.PRE_CYCLES(1), .LOAD_CYCLES(1), .POST_CYCLES(1)) dut_min (
    .CLK(CLK), .RESET(RESET), .UPD_REQ(m_upd_req), .UPD_CODE(m_upd_code),
    .UPD_ACK(m_upd_ack), .HS_IO_CLK_PAUSE(m_pause), .DLY_LOAD(m_dly_load),
    .DLY_CODE(m_dly_code), .BUSY(m_busy)
  );

  // Load strobe must never appear without the pause on either instance.
  always @(negedge CLK) begin
    if (!RESET) begin
      checks++;
      if ((dly_load && !pause) || (m_dly_load && !m_pause)) begin
        errors++;
        $display("FAIL load_without_pause: load=%b pause=%b m_load=%b m_pause=%b, required no load while pause low",
                 dly_load, pause, m_dly_load, m_pause);
      end
    end
  end

  task automatic wait_ack(input int max_cycles);
    int n = 0;
    while (upd_ack !== 1'b1 && n < max_cycles) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (upd_ack !== 1'b1) begin
      errors++;
      $display("FAIL wait_ack: ack=%b after %0d cycles, required 1", upd_ack, n);
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({upd_ack, pause, dly_load, busy, dly_code} !== 12'h000 ||
        {m_upd_ack, m_pause, m_dly_load, m_busy, m_dly_code} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: ack=%b pause=%b load=%b busy=%b code=%h, required all 0",
               upd_ack, pause, dly_load, busy, dly_code);
    end
  endtask

  // Full sequence with defaults; code change during PRE must be ignored.
  task automatic test_basic;
    upd_code = 8'h5A;
    upd_req  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (i == 3) upd_code = 8'hFF;
      checks++;
      if (pause !== 1'b1 || dly_load !== (i == 5 || i == 6) || upd_ack !== 1'b0 ||
          busy !== 1'b1 || dly_code !== 8'h5A) begin
        errors++;
        $display("FAIL basic_cycle%0d: pause=%b load=%b ack=%b busy=%b code=%h, required 1 %b 0 1 5a",
                 i, pause, dly_load, upd_ack, busy, dly_code, (i == 5 || i == 6));
      end
    end
    @(negedge CLK);
    checks++;
    if (pause !== 1'b0 || upd_ack !== 1'b1 || dly_load !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_ack: pause=%b ack=%b load=%b busy=%b, required 0 1 0 1",
               pause, upd_ack, dly_load, busy);
    end
    upd_req = 1'b0;
    @(negedge CLK);
    checks++;
    if (upd_ack !== 1'b0 || busy !== HOLD_EN || dly_code !== 8'h5A) begin
      errors++;
      $display("FAIL basic_release: ack=%b busy=%b code=%h, required 0 %b 5a",
               upd_ack, busy, dly_code, HOLD_EN);
    end
    wait_idle(20);
  endtask

  task automatic test_pulse;
    int ack_cycles = 0;
    upd_code = 8'hC3;
    upd_req  = 1'b1;
    @(negedge CLK);
    upd_req = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) @(negedge CLK);
      checks++;
      if (pause !== 1'b1 || dly_code !== 8'hC3) begin
        errors++;
        $display("FAIL pulse_pause_cycle%0d: pause=%b code=%h, required 1 c3", i, pause, dly_code);
      end
    end
    for (int i = 11; i <= 13; i++) begin
      @(negedge CLK);
      if (upd_ack === 1'b1) ack_cycles++;
    end
    checks++;
    if (ack_cycles != 1 || pause !== 1'b0) begin
      errors++;
      $display("FAIL pulse_ack_width: ack cycles=%0d pause=%b, required 1 0", ack_cycles, pause);
    end
    wait_idle(20);
  endtask

  task automatic test_reset_mid;
    upd_code = 8'h3C;
    upd_req  = 1'b1;
    for (int i = 1; i <= 5; i++) @(negedge CLK);
    checks++;
    if (dly_load !== 1'b1) begin
      errors++;
      $display("FAIL reset_setup_load: load=%b, required 1", dly_load);
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (pause !== 1'b0 || dly_load !== 1'b0 || busy !== 1'b0 || upd_ack !== 1'b0 || dly_code !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: pause=%b load=%b busy=%b ack=%b code=%h, required 0 0 0 0 00",
               pause, dly_load, busy, upd_ack, dly_code);
    end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (pause !== 1'b1 || busy !== 1'b1 || dly_code !== 8'h3C || dly_load !== 1'b0) begin
      errors++;
      $display("FAIL reset_restart: pause=%b busy=%b code=%h load=%b, required 1 1 3c 0",
               pause, busy, dly_code, dly_load);
    end
    wait_ack(20);
    upd_req = 1'b0;
    @(negedge CLK);
    wait_idle(20);
  endtask

  task automatic test_back_to_back;
    upd_code = 8'h11;
    upd_req  = 1'b1;
    wait_ack(20);
    upd_req = 1'b0;
    for (int j = 1; j <= B2B_GAP + 1; j++) begin
      @(negedge CLK);
      if (j == 1) begin
        checks++;
        if (upd_ack !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ack_drop: ack=%b, required 0", upd_ack);
        end
        upd_code = 8'h22;
        upd_req  = 1'b1;
      end
      checks++;
      if (pause !== (j >= B2B_GAP)) begin
        errors++;
        $display("FAIL b2b_pause_j%0d: pause=%b, required %b", j, pause, (j >= B2B_GAP));
      end
    end
    checks++;
    if (dly_code !== 8'h22) begin
      errors++;
      $display("FAIL b2b_code: code=%h, required 22", dly_code);
    end
    wait_ack(20);
    upd_req = 1'b0;
    @(negedge CLK);
    wait_idle(20);
  endtask

  task automatic test_min_params;
    m_upd_code = 8'hA5;
    m_upd_req  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      checks++;
      if (m_pause !== 1'b1 || m_dly_load !== (i == 2) || m_upd_ack !== 1'b0 || m_dly_code !== 8'hA5) begin
        errors++;
        $display("FAIL min_cycle%0d: pause=%b load=%b ack=%b code=%h, required 1 %b 0 a5",
                 i, m_pause, m_dly_load, m_upd_ack, m_dly_code, (i == 2));
      end
    end
    @(negedge CLK);
    checks++;
    if (m_pause !== 1'b0 || m_upd_ack !== 1'b1 || m_dly_load !== 1'b0) begin
      errors++;
      $display("FAIL min_ack: pause=%b ack=%b load=%b, required 0 1 0", m_pause, m_upd_ack, m_dly_load);
    end
    m_upd_req = 1'b0;
    @(negedge CLK);
    checks++;
    if (m_upd_ack !== 1'b0 || m_busy !== HOLD_EN) begin
      errors++;
      $display("FAIL min_release: ack=%b busy=%b, required 0 %b", m_upd_ack, m_busy, HOLD_EN);
    end
    for (int i = 0; i < 12; i++) @(negedge CLK);
  endtask

  initial begin
    #3;
    test_reset;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    test_basic;
    test_pulse;
    test_reset_mid;
    test_back_to_back;
    test_min_params;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
